// File: rtl/rom_fetch_arbiter.sv
// rom_fetch_arbiter
// Shares one SDRAM toggle-handshake port between three byte-addressed ROM
// readers (0 = main CPU, 1 = sound CPU, 2 = sprite ROM) and the ROM download
// write stream. A pending download write always wins. Reads are granted
// round-robin, and each reader keeps a one-word cache of its last fetched word.
//
// Ports
//   clk_sys               system clock
//   reset                 synchronous, active-high
//   dl_active             ROM download in progress
//   dl_wr                 download byte strobe (a write is triggered on its rising edge)
//   dl_addr[24:0]         download byte address
//   dl_data[7:0]          download byte
//   rd_req[2:0]           per-reader read request (level, held until ack)
//   rd_addr0/1/2[16:0]    reader byte address (stable while requesting)
//   rd_ack[2:0]           one-cycle pulse: matching rd_q is valid
//   rd_q0/1/2[7:0]        returned byte, held until that reader's next ack
//   sd_req                SDRAM request toggle (not touched by reset)
//   sd_ack                SDRAM ack toggle (foreign clock domain)
//   sd_we, sd_a, sd_ds,   SDRAM command: write flag, word address,
//   sd_d                  byte enables {upper,lower}, write data
//   sd_q[15:0]            SDRAM read data, valid once the ack toggles
//   dl_overrun            sticky flag: a download byte was dropped
module rom_fetch_arbiter #(
    parameter int              AW    = 23,
    parameter logic [AW-1:0]   BASE0 = 23'h04000,
    parameter logic [AW-1:0]   BASE1 = 23'h00000,
    parameter logic [AW-1:0]   BASE2 = 23'h10000
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          dl_active,
    input  logic          dl_wr,
    input  logic [24:0]   dl_addr,
    input  logic [7:0]    dl_data,
    input  logic [2:0]    rd_req,
    input  logic [16:0]   rd_addr0,
    input  logic [16:0]   rd_addr1,
    input  logic [16:0]   rd_addr2,
    output logic [2:0]    rd_ack,
    output logic [7:0]    rd_q0,
    output logic [7:0]    rd_q1,
    output logic [7:0]    rd_q2,
    output logic          sd_req,
    input  logic          sd_ack,
    output logic          sd_we,
    output logic [AW-1:0] sd_a,
    output logic [1:0]    sd_ds,
    output logic [15:0]   sd_d,
    input  logic [15:0]   sd_q,
    output logic          dl_overrun
);

    typedef enum logic [1:0] {
        ST_DRAIN = 2'd0,
        ST_IDLE  = 2'd1,
        ST_BUSY  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t state_r;
    state_t state_s;

    // The request toggle must survive reset so an outstanding transaction is
    // never doubled up; it only gets a power-up value.
    logic sd_req_r   = 1'b0;
    logic ack_meta_r = 1'b0;
    logic ack_sync_r = 1'b0;

    logic [1:0]    rr_ptr_r;
    logic [1:0]    cur_idx_r;
    logic [16:0]   cur_addr_r;
    logic [2:0]    cache_v_r;
    logic [15:0]   cache_word_r [3];
    logic [15:0]   cache_tag_r  [3];
    logic          pend_v_r;
    logic [23:0]   pend_a_r;
    logic [7:0]    pend_d_r;
    logic          dl_wr_d_r;
    logic          dl_active_d_r;
    logic [2:0]    rd_ack_r;
    logic [7:0]    rd_q0_r;
    logic [7:0]    rd_q1_r;
    logic [7:0]    rd_q2_r;
    logic          sd_we_r;
    logic [AW-1:0] sd_a_r;
    logic [1:0]    sd_ds_r;
    logic [15:0]   sd_d_r;
    logic          dl_overrun_r;

    logic          done_s;
    logic          gnt_v_s;
    logic [1:0]    gnt_idx_s;
    logic [16:0]   sel_addr_s;
    logic [AW-1:0] sel_base_s;
    logic          hit_s;
    logic          grant_s;
    logic          issue_wr_s;
    logic          issue_rd_s;
    logic          fill_s;
    logic          resp_s;
    logic          dl_edge_s;
    logic          dl_rise_s;
    logic [15:0]   resp_word_s;
    logic [7:0]    resp_byte_s;

    // Returns {valid, index} of the first requester after ptr, in circular order.
    function automatic logic [2:0] rr_pick(input logic [1:0] ptr, input logic [2:0] req);
        logic [1:0] first_s;
        logic [1:0] second_s;
        logic [1:0] third_s;
        case (ptr)
            2'd0:    begin first_s = 2'd1; second_s = 2'd2; third_s = 2'd0; end
            2'd1:    begin first_s = 2'd2; second_s = 2'd0; third_s = 2'd1; end
            default: begin first_s = 2'd0; second_s = 2'd1; third_s = 2'd2; end
        endcase
        if (req[first_s]) begin
            rr_pick = {1'b1, first_s};
        end else if (req[second_s]) begin
            rr_pick = {1'b1, second_s};
        end else if (req[third_s]) begin
            rr_pick = {1'b1, third_s};
        end else begin
            rr_pick = 3'b000;
        end
    endfunction

    assign done_s    = (ack_sync_r == sd_req_r);
    assign dl_edge_s = dl_active && dl_wr && !dl_wr_d_r;
    assign dl_rise_s = dl_active && !dl_active_d_r;
    assign {gnt_v_s, gnt_idx_s} = rr_pick(rr_ptr_r, rd_req);

    // Address, base offset and cache-hit test for the reader that would be granted.
    always_comb begin
        sel_addr_s = rd_addr0;
        sel_base_s = BASE0;
        hit_s      = 1'b0;
        case (gnt_idx_s)
            2'd1: begin
                sel_addr_s = rd_addr1;
                sel_base_s = BASE1;
                hit_s      = cache_v_r[1] && (cache_tag_r[1] == rd_addr1[16:1]);
            end
            2'd2: begin
                sel_addr_s = rd_addr2;
                sel_base_s = BASE2;
                hit_s      = cache_v_r[2] && (cache_tag_r[2] == rd_addr2[16:1]);
            end
            default: begin
                sel_addr_s = rd_addr0;
                sel_base_s = BASE0;
                hit_s      = cache_v_r[0] && (cache_tag_r[0] == rd_addr0[16:1]);
            end
        endcase
    end

    // Cached word and byte returned to the reader being acknowledged.
    always_comb begin
        resp_word_s = cache_word_r[0];
        case (cur_idx_r)
            2'd1:    resp_word_s = cache_word_r[1];
            2'd2:    resp_word_s = cache_word_r[2];
            default: resp_word_s = cache_word_r[0];
        endcase
        if (cur_addr_r[0]) begin
            resp_byte_s = resp_word_s[15:8];
        end else begin
            resp_byte_s = resp_word_s[7:0];
        end
    end

    // Next-state logic and per-cycle action strobes.
    always_comb begin
        state_s    = state_r;
        grant_s    = 1'b0;
        issue_wr_s = 1'b0;
        issue_rd_s = 1'b0;
        fill_s     = 1'b0;
        resp_s     = 1'b0;
        case (state_r)
            ST_DRAIN: begin
                if (done_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_IDLE: begin
                if (pend_v_r) begin
                    issue_wr_s = 1'b1;
                    state_s    = ST_BUSY;
                end else if (!dl_active && gnt_v_s) begin
                    grant_s = 1'b1;
                    if (hit_s) begin
                        state_s = ST_RESP;
                    end else begin
                        issue_rd_s = 1'b1;
                        state_s    = ST_BUSY;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (done_s) begin
                    if (sd_we_r) begin
                        state_s = ST_IDLE;
                    end else begin
                        fill_s  = 1'b1;
                        state_s = ST_RESP;
                    end
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_RESP: begin
                resp_s  = 1'b1;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_DRAIN;
            end
        endcase
    end

    // State register; reset parks in DRAIN until any old transaction completes.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_r <= ST_DRAIN;
        end else begin
            state_r <= state_s;
        end
    end

    // Two-flop synchroniser for the foreign-domain ack toggle (no reset on purpose).
    always_ff @(posedge clk_sys) begin
        ack_meta_r <= sd_ack;
        ack_sync_r <= ack_meta_r;
    end

    // Request toggle: flips once per issued SDRAM command.
    always_ff @(posedge clk_sys) begin
        if (!reset && (issue_wr_s || issue_rd_s)) begin
            sd_req_r <= ~sd_req_r;
        end else begin
            sd_req_r <= sd_req_r;
        end
    end

    // SDRAM command registers, loaded in the cycle the toggle is issued.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sd_we_r <= 1'b0;
            sd_a_r  <= {AW{1'b0}};
            sd_ds_r <= 2'b00;
            sd_d_r  <= 16'h0000;
        end else if (issue_wr_s) begin
            sd_we_r <= 1'b1;
            sd_a_r  <= AW'(pend_a_r[23:1]);
            sd_ds_r <= {pend_a_r[0], ~pend_a_r[0]};
            sd_d_r  <= {pend_d_r, pend_d_r};
        end else if (issue_rd_s) begin
            sd_we_r <= 1'b0;
            sd_a_r  <= sel_base_s + {{(AW-16){1'b0}}, sel_addr_s[16:1]};
            sd_ds_r <= 2'b11;
        end
    end

    // One-deep download write buffer and sticky overrun flag.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dl_wr_d_r    <= 1'b0;
            pend_v_r     <= 1'b0;
            pend_a_r     <= 24'h000000;
            pend_d_r     <= 8'h00;
            dl_overrun_r <= 1'b0;
        end else begin
            dl_wr_d_r <= dl_wr;
            if (dl_edge_s) begin
                // A slot being issued this cycle is free for the new byte.
                if (pend_v_r && !issue_wr_s) begin
                    dl_overrun_r <= 1'b1;
                end else begin
                    pend_v_r <= 1'b1;
                    pend_a_r <= dl_addr[23:0];
                    pend_d_r <= dl_data;
                end
            end else if (issue_wr_s) begin
                pend_v_r <= 1'b0;
            end
        end
    end

    // Grant bookkeeping: which reader and address the current transaction serves.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cur_idx_r  <= 2'd0;
            cur_addr_r <= 17'h00000;
        end else if (grant_s) begin
            cur_idx_r  <= gnt_idx_s;
            cur_addr_r <= sel_addr_s;
        end
    end

    // Cache valid bits: set on fill, all cleared when a download starts.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            dl_active_d_r <= 1'b0;
            cache_v_r     <= 3'b000;
        end else begin
            dl_active_d_r <= dl_active;
            if (dl_rise_s) begin
                cache_v_r <= 3'b000;
            end else if (fill_s) begin
                cache_v_r <= cache_v_r | (3'b001 << cur_idx_r);
            end
        end
    end

    // Cache word and tag storage, only meaningful where the valid bit is set.
    always_ff @(posedge clk_sys) begin
        if (fill_s) begin
            cache_word_r[cur_idx_r] <= sd_q;
            cache_tag_r[cur_idx_r]  <= cur_addr_r[16:1];
        end
    end

    // Reader responses and round-robin pointer; a dropped request gets no ack.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rd_ack_r <= 3'b000;
            rd_q0_r  <= 8'h00;
            rd_q1_r  <= 8'h00;
            rd_q2_r  <= 8'h00;
            rr_ptr_r <= 2'd2;
        end else begin
            rd_ack_r <= 3'b000;
            if (resp_s) begin
                rr_ptr_r <= cur_idx_r;
                if (rd_req[cur_idx_r]) begin
                    rd_ack_r <= 3'b001 << cur_idx_r;
                    case (cur_idx_r)
                        2'd1:    rd_q1_r <= resp_byte_s;
                        2'd2:    rd_q2_r <= resp_byte_s;
                        default: rd_q0_r <= resp_byte_s;
                    endcase
                end
            end
        end
    end

    assign rd_ack     = rd_ack_r;
    assign rd_q0      = rd_q0_r;
    assign rd_q1      = rd_q1_r;
    assign rd_q2      = rd_q2_r;
    assign sd_req     = sd_req_r;
    assign sd_we      = sd_we_r;
    assign sd_a       = sd_a_r;
    assign sd_ds      = sd_ds_r;
    assign sd_d       = sd_d_r;
    assign dl_overrun = dl_overrun_r;

endmodule

// File: tb/tb_rom_fetch_arbiter.sv
`timescale 1ns/1ps
module tb_rom_fetch_arbiter;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        dl_active = 1'b0;
    logic        dl_wr = 1'b0;
    logic [24:0] dl_addr = 25'h0;
    logic [7:0]  dl_data = 8'h00;
    logic [2:0]  rd_req = 3'b000;
    logic [16:0] rd_addr0 = 17'h0;
    logic [16:0] rd_addr1 = 17'h0;
    logic [16:0] rd_addr2 = 17'h0;
    logic [2:0]  rd_ack;
    logic [7:0]  rd_q0, rd_q1, rd_q2;
    logic        sd_req;
    logic        sd_ack = 1'b0;
    logic        sd_we;
    logic [22:0] sd_a;
    logic [1:0]  sd_ds;
    logic [15:0] sd_d;
    logic [15:0] sd_q = 16'h0000;
    logic        dl_overrun;

    int checks = 0;
    int errors = 0;

    rom_fetch_arbiter dut (
        .clk_sys(clk_sys), .reset(reset), .dl_active(dl_active), .dl_wr(dl_wr),
        .dl_addr(dl_addr), .dl_data(dl_data), .rd_req(rd_req),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_ack(rd_ack), .rd_q0(rd_q0), .rd_q1(rd_q1), .rd_q2(rd_q2),
        .sd_req(sd_req), .sd_ack(sd_ack), .sd_we(sd_we), .sd_a(sd_a),
        .sd_ds(sd_ds), .sd_d(sd_d), .sd_q(sd_q), .dl_overrun(dl_overrun)
    );

    always #5 clk_sys = ~clk_sys;

    // SDRAM responder: logs every new request and toggles ack after a delay.
    logic        req_prev = 1'b0;
    int          tog_cnt = 0;
    int          pend_cnt = 0;
    int          ack_delay = 4;
    bit          ack_hold = 1'b0;
    logic [22:0] log_a[$];
    logic        log_we[$];
    logic [1:0]  log_ds[$];
    logic [15:0] log_d[$];

    function automatic logic [15:0] mem_word(input logic [22:0] a);
        mem_word = {a[7:0] ^ 8'h3C, a[7:0]};
    endfunction

    always @(negedge clk_sys) begin
        if (sd_req !== req_prev) begin
            tog_cnt++;
            log_a.push_back(sd_a);
            log_we.push_back(sd_we);
            log_ds.push_back(sd_ds);
            log_d.push_back(sd_d);
            req_prev = sd_req;
            pend_cnt = 0;
        end
        if ((sd_req != sd_ack) && !ack_hold) begin
            pend_cnt++;
            if (pend_cnt >= ack_delay) begin
                sd_q   = mem_word(sd_a);
                sd_ack = sd_req;
            end
        end
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_ack(input int n, input int budget, output int cyc, output bit got);
        got = 1'b0;
        cyc = 0;
        for (int i = 0; i < budget; i++) begin
            if (!got) begin
                tick();
                cyc++;
                if (rd_ack[n]) got = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++; if (rd_ack !== 3'b000) begin errors++; $display("FAIL reset_rd_ack got %b want 000", rd_ack); end
        checks++; if ({rd_q0, rd_q1, rd_q2} !== 24'h0) begin errors++; $display("FAIL reset_rd_q got %h want 000000", {rd_q0, rd_q1, rd_q2}); end
        checks++; if (sd_we !== 1'b0) begin errors++; $display("FAIL reset_sd_we got %b want 0", sd_we); end
        checks++; if (sd_a !== 23'h0) begin errors++; $display("FAIL reset_sd_a got %h want 0", sd_a); end
        checks++; if ({sd_ds, sd_d} !== 18'h0) begin errors++; $display("FAIL reset_sd_ds_d got %h want 0", {sd_ds, sd_d}); end
        checks++; if (dl_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", dl_overrun); end
        reset = 1'b0;
        repeat (4) tick();
        checks++; if (tog_cnt != 0) begin errors++; $display("FAIL reset_idle_toggles got %0d want 0", tog_cnt); end
    endtask

    task automatic test_dl_write();
        int base;
        base = tog_cnt;
        dl_active = 1'b1;
        tick();
        dl_addr = 25'h0008001; dl_data = 8'hAA; dl_wr = 1'b1;
        tick();
        dl_wr = 1'b0;
        repeat (5) tick();
        dl_addr = 25'h0008002; dl_data = 8'h55; dl_wr = 1'b1;
        tick();
        dl_wr = 1'b0;
        repeat (20) tick();
        checks++; if (tog_cnt != base + 2) begin errors++; $display("FAIL wr_count got %0d want %0d", tog_cnt - base, 2); end
        checks++; if ({log_we[base], log_a[base], log_ds[base], log_d[base]} !== {1'b1, 23'h4000, 2'b10, 16'hAAAA})
            begin errors++; $display("FAIL wr1 got we=%b a=%h ds=%b d=%h want we=1 a=4000 ds=10 d=AAAA", log_we[base], log_a[base], log_ds[base], log_d[base]); end
        checks++; if ({log_we[base+1], log_a[base+1], log_ds[base+1], log_d[base+1]} !== {1'b1, 23'h4001, 2'b01, 16'h5555})
            begin errors++; $display("FAIL wr2 got we=%b a=%h ds=%b d=%h want we=1 a=4001 ds=01 d=5555", log_we[base+1], log_a[base+1], log_ds[base+1], log_d[base+1]); end
        checks++; if (dl_overrun !== 1'b0) begin errors++; $display("FAIL wr_overrun got %b want 0", dl_overrun); end
    endtask

    task automatic test_overrun();
        int base;
        base = tog_cnt;
        ack_hold = 1'b1;
        dl_addr = 25'h0000100; dl_data = 8'h11; dl_wr = 1'b1; tick(); dl_wr = 1'b0; tick();
        dl_addr = 25'h0000101; dl_data = 8'h22; dl_wr = 1'b1; tick(); dl_wr = 1'b0; tick();
        dl_addr = 25'h0000102; dl_data = 8'h33; dl_wr = 1'b1; tick(); dl_wr = 1'b0; tick();
        checks++; if (dl_overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", dl_overrun); end
        checks++; if (tog_cnt != base + 1) begin errors++; $display("FAIL ovr_held_count got %0d want 1", tog_cnt - base); end
        ack_hold = 1'b0;
        repeat (30) tick();
        checks++; if (tog_cnt != base + 2) begin errors++; $display("FAIL ovr_total_count got %0d want 2", tog_cnt - base); end
        checks++; if ({log_a[base+1], log_ds[base+1], log_d[base+1]} !== {23'h80, 2'b10, 16'h2222})
            begin errors++; $display("FAIL ovr_second got a=%h ds=%b d=%h want a=80 ds=10 d=2222", log_a[base+1], log_ds[base+1], log_d[base+1]); end
        checks++; if (dl_overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", dl_overrun); end
        dl_active = 1'b0;
        tick();
    endtask

    task automatic test_drain();
        int base;
        int cyc;
        bit got;
        ack_hold = 1'b1;
        base = tog_cnt;
        rd_addr0 = 17'h00020; rd_req = 3'b001;
        for (int i = 0; i < 10; i++) if (tog_cnt == base) tick();
        checks++; if (tog_cnt != base + 1) begin errors++; $display("FAIL drain_first_issue got %0d want 1", tog_cnt - base); end
        rd_req = 3'b000;
        reset = 1'b1;
        repeat (2) tick();
        checks++; if (dl_overrun !== 1'b0) begin errors++; $display("FAIL drain_overrun_cleared got %b want 0", dl_overrun); end
        reset = 1'b0;
        rd_addr1 = 17'h00030; rd_req = 3'b010;
        base = tog_cnt;
        repeat (8) tick();
        checks++; if (tog_cnt != base) begin errors++; $display("FAIL drain_no_toggle got %0d want 0", tog_cnt - base); end
        ack_hold = 1'b0;
        wait_ack(1, 40, cyc, got);
        checks++; if (!got) begin errors++; $display("FAIL drain_ack got none want ack within 40"); end
        checks++; if (tog_cnt != base + 1) begin errors++; $display("FAIL drain_count got %0d want 1", tog_cnt - base); end
        checks++; if (log_a[base] !== 23'h18) begin errors++; $display("FAIL drain_sd_a got %h want 18", log_a[base]); end
        checks++; if (rd_q1 !== 8'h18) begin errors++; $display("FAIL drain_rd_q1 got %h want 18", rd_q1); end
        rd_req = 3'b000;
        tick();
    endtask

    task automatic test_round_robin();
        int base;
        int order[3];
        int n_acks;
        logic [22:0] exp_a[3];
        logic [7:0]  exp_q[3];
        logic [7:0]  got_q[3];
        exp_a[0] = 23'h04001; exp_a[1] = 23'h00002; exp_a[2] = 23'h10003;
        exp_q[0] = 8'h01; exp_q[1] = 8'h02; exp_q[2] = 8'h03;
        reset = 1'b1; repeat (2) tick(); reset = 1'b0;
        base = tog_cnt;
        n_acks = 0;
        rd_addr0 = 17'h00002; rd_addr1 = 17'h00004; rd_addr2 = 17'h00006;
        rd_req = 3'b111;
        for (int i = 0; i < 120; i++) begin
            if (n_acks < 3) begin
                tick();
                if (rd_ack != 3'b000) begin
                    order[n_acks] = (rd_ack == 3'b001) ? 0 : (rd_ack == 3'b010) ? 1 : (rd_ack == 3'b100) ? 2 : 9;
                    got_q[n_acks] = (rd_ack == 3'b001) ? rd_q0 : (rd_ack == 3'b010) ? rd_q1 : rd_q2;
                    rd_req = rd_req & ~rd_ack;
                    n_acks++;
                end
            end
        end
        checks++; if (n_acks != 3) begin errors++; $display("FAIL rr_ack_count got %0d want 3", n_acks); end
        for (int k = 0; k < 3; k++) begin
            if (k < n_acks) begin
                checks++; if (order[k] != k) begin errors++; $display("FAIL rr_order[%0d] got %0d want %0d", k, order[k], k); end
                checks++; if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL rr_rd_q[%0d] got %h want %h", k, got_q[k], exp_q[k]); end
            end
            checks++; if (log_a[base+k] !== exp_a[k]) begin errors++; $display("FAIL rr_sd_a[%0d] got %h want %h", k, log_a[base+k], exp_a[k]); end
        end
        rd_req = 3'b000;
        tick();
    endtask

    task automatic test_cache_hit();
        int base;
        int cyc;
        bit got;
        rd_addr0 = 17'h00010; rd_req = 3'b001;
        base = tog_cnt;
        wait_ack(0, 40, cyc, got);
        checks++; if (!got) begin errors++; $display("FAIL hit_first_ack got none want ack within 40"); end
        checks++; if (log_a[base] !== 23'h04008) begin errors++; $display("FAIL hit_first_sd_a got %h want 04008", log_a[base]); end
        checks++; if (rd_q0 !== 8'h08) begin errors++; $display("FAIL hit_first_rd_q0 got %h want 08", rd_q0); end
        rd_req = 3'b000;
        tick();
        base = tog_cnt;
        rd_addr0 = 17'h00011; rd_req = 3'b001;
        wait_ack(0, 10, cyc, got);
        checks++; if (!got || cyc != 2) begin errors++; $display("FAIL hit_latency got %0d (ack %b) want 2", cyc, got); end
        checks++; if (tog_cnt != base) begin errors++; $display("FAIL hit_no_sdram got %0d want 0", tog_cnt - base); end
        checks++; if (rd_q0 !== 8'h34) begin errors++; $display("FAIL hit_upper_byte got %h want 34", rd_q0); end
        rd_req = 3'b000;
        tick();
    endtask

    task automatic test_invalidate();
        int base;
        int cyc;
        bit got;
        bit any_ack;
        rd_addr2 = 17'h00100; rd_req = 3'b100;
        wait_ack(2, 40, cyc, got);
        checks++; if (!got) begin errors++; $display("FAIL inv_fill_ack got none want ack within 40"); end
        rd_req = 3'b000; tick();
        base = tog_cnt;
        rd_req = 3'b100;
        wait_ack(2, 10, cyc, got);
        checks++; if (!got || tog_cnt != base) begin errors++; $display("FAIL inv_prehit got ack=%b toggles=%0d want ack=1 toggles=0", got, tog_cnt - base); end
        rd_req = 3'b000; tick();
        dl_active = 1'b1; rd_req = 3'b100;
        any_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rd_ack != 3'b000) any_ack = 1'b1;
        end
        checks++; if (any_ack) begin errors++; $display("FAIL inv_no_ack_during_dl got ack want none"); end
        checks++; if (tog_cnt != base) begin errors++; $display("FAIL inv_no_read_during_dl got %0d want 0", tog_cnt - base); end
        dl_active = 1'b0;
        wait_ack(2, 40, cyc, got);
        checks++; if (!got) begin errors++; $display("FAIL inv_after_ack got none want ack within 40"); end
        checks++; if (tog_cnt != base + 1) begin errors++; $display("FAIL inv_miss got %0d want 1", tog_cnt - base); end
        checks++; if (log_a[base] !== 23'h10080) begin errors++; $display("FAIL inv_sd_a got %h want 10080", log_a[base]); end
        checks++; if (rd_q2 !== 8'h80) begin errors++; $display("FAIL inv_rd_q2 got %h want 80", rd_q2); end
        rd_req = 3'b000;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_dl_write();
        test_overrun();
        test_drain();
        test_round_robin();
        test_cache_hit();
        test_invalidate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
